coef_mult_array: RTL

- Multiplier stage directly upstream of the 49-tap DSP adder tree.
- Takes a 7x7 window of unsigned pixels and multiplies each pixel by a programmable signed coefficient.
- Emits the packed p*c product vector that the adder tree consumes on its term input, plus a valid flag aligned to it.
- Coefficients are double-buffered: a shadow bank is written through a register port, and a commit copies it to the active bank so the kernel can change between frames without glitching in-flight products.

---
 rtl/coef_mult_array_if.sv | 32 +++
 rtl/coef_mult_array.sv | 79 +++++++
 2 files changed

// File: rtl/coef_mult_array_if.sv
// Window/coefficient/product bundle between the window source, the coefficient
// register port and the downstream 49-tap adder tree.
interface coef_mult_array_if #(
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7,
  parameter int unsigned COFCNT_BIT = 15,
  parameter int unsigned TERM_SIZE  = MASK_WIDTH * MASK_WIDTH,
  parameter int unsigned ADDR_BIT   = 6
);
  localparam int unsigned W = PIX_BIT + COFCNT_BIT + 1;

  logic [PIX_BIT*TERM_SIZE-1:0] win_in;
  logic                         win_valid;
  logic                         coef_we;
  logic [ADDR_BIT-1:0]          coef_addr;
  logic [COFCNT_BIT:0]          coef_data;
  logic                         coef_commit;
  logic [W*TERM_SIZE-1:0]       term_out;
  logic                         term_valid;
  logic                         coef_ready;
  logic                         addr_err;

  modport master (
    output win_in, win_valid, coef_we, coef_addr, coef_data, coef_commit,
    input  term_out, term_valid, coef_ready, addr_err
  );

  modport slave (
    input  win_in, win_valid, coef_we, coef_addr, coef_data, coef_commit,
    output term_out, term_valid, coef_ready, addr_err
  );
endinterface

// File: rtl/coef_mult_array.sv
// Per-tap pixel x signed coefficient multiplier stage with double-buffered
// coefficients; 2-cycle latency, feeds the 49-tap adder tree.
module coef_mult_array #(
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7,
  parameter int unsigned COFCNT_BIT = 15,
  parameter int unsigned TERM_SIZE  = MASK_WIDTH * MASK_WIDTH,
  parameter int unsigned ADDR_BIT   = 6
) (
  input logic               clk,
  input logic               reset,
  coef_mult_array_if.slave  bus
);
  localparam int unsigned CW = COFCNT_BIT + 1;
  localparam int unsigned W  = PIX_BIT + CW;
  localparam logic [ADDR_BIT:0] TermLimit = (ADDR_BIT + 1)'(TERM_SIZE);

  logic signed [CW-1:0]   shadow_q [TERM_SIZE];
  logic signed [CW-1:0]   active_q [TERM_SIZE];
  logic signed [W-1:0]    prod_d   [TERM_SIZE];
  logic signed [W-1:0]    prod_q   [TERM_SIZE];
  logic [W*TERM_SIZE-1:0] term_q;
  logic                   v1_q;
  logic                   term_valid_q;
  logic                   coef_ready_q;
  logic                   addr_err_q;
  logic                   addr_ok;

  assign addr_ok = ({1'b0, bus.coef_addr} < TermLimit);

  // Pixel is zero-extended (unsigned), coefficient sign-extended; W bits hold the exact product.
  always_comb begin
    for (int k = 0; k < TERM_SIZE; k++) begin
      prod_d[k] = $signed({{(W - PIX_BIT){1'b0}}, bus.win_in[PIX_BIT*k +: PIX_BIT]}) *
                  $signed({{PIX_BIT{active_q[k][CW-1]}}, active_q[k]});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TERM_SIZE; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
        prod_q[k]   <= '0;
      end
      term_q       <= '0;
      v1_q         <= 1'b0;
      term_valid_q <= 1'b0;
      coef_ready_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      if (bus.coef_we) begin
        if (addr_ok) begin
          shadow_q[bus.coef_addr] <= bus.coef_data;
        end else begin
          addr_err_q <= 1'b1;
        end
      end
      // Non-blocking copy takes the pre-write shadow when we and commit coincide.
      if (bus.coef_commit) begin
        active_q     <= shadow_q;
        coef_ready_q <= 1'b1;
      end
      prod_q <= prod_d;
      v1_q   <= bus.win_valid & coef_ready_q;
      if (v1_q) begin
        for (int k = 0; k < TERM_SIZE; k++) begin
          term_q[W*k +: W] <= prod_q[k];
        end
      end
      term_valid_q <= v1_q;
    end
  end

  assign bus.term_out   = term_q;
  assign bus.term_valid = term_valid_q;
  assign bus.coef_ready = coef_ready_q;
  assign bus.addr_err   = addr_err_q;
endmodule
